// File: rtl/multirate_stream_bridge_pkg.sv
// Shared sizing helpers for the multi-rate stream bridge.
package multirate_stream_bridge_pkg;

    // Pointer carries one extra wrap bit over the buffer index.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // A 1-entry buffer still needs a 1-bit index to declare storage.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/multirate_stream_bridge_channel.sv
// One bridge channel: write/read pointers, enable-gated cross copies and the
// payload buffer. Source state moves on src_en_i, destination on dst_en_i.
module multirate_stream_bridge_channel
    import multirate_stream_bridge_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int Depth     = 2,
    parameter int PtrWidth  = ptr_width(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 src_en_i,
    input  logic                 dst_en_i,
    input  logic                 src_valid_i,
    output logic                 src_ready_o,
    input  logic [DataWidth-1:0] src_data_i,
    output logic                 dst_valid_o,
    input  logic                 dst_ready_i,
    output logic [DataWidth-1:0] dst_data_o
);

    localparam int IdxWidth   = idx_width(Depth);
    localparam int BufEntries = 2 ** IdxWidth;
    localparam logic [PtrWidth-1:0] DepthP = PtrWidth'(Depth);
    localparam logic [PtrWidth-1:0] PtrOne = PtrWidth'(1);

    logic [PtrWidth-1:0]  r_wptr;
    logic [PtrWidth-1:0]  r_rptr;
    logic [PtrWidth-1:0]  r_wptr_dst;
    logic [PtrWidth-1:0]  r_rptr_src;
    logic [DataWidth-1:0] r_buf [BufEntries];

    logic [IdxWidth-1:0]  w_widx;
    logic [IdxWidth-1:0]  w_ridx;
    logic [PtrWidth-1:0]  w_occ_src;
    logic                 w_push;
    logic                 w_pop;

    generate
        if (Depth == 1) begin : g_single
            assign w_widx = '0;
            assign w_ridx = '0;
        end else begin : g_multi
            assign w_widx = r_wptr[PtrWidth-2:0];
            assign w_ridx = r_rptr[PtrWidth-2:0];
        end
    endgenerate

    // Source sees the read pointer late, so a slot being read is still
    // counted as occupied and the write index can never hit the read index.
    assign w_occ_src   = r_wptr - r_rptr_src;
    assign src_ready_o = (w_occ_src != DepthP);
    assign dst_valid_o = (r_wptr_dst != r_rptr);
    assign dst_data_o  = dst_valid_o ? r_buf[w_ridx] : '0;

    assign w_push = src_en_i & src_valid_i & src_ready_o;
    assign w_pop  = dst_en_i & dst_valid_o & dst_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr_src <= '0;
            for (int i = 0; i < BufEntries; i++) r_buf[i] <= '0;
        end else if (src_en_i) begin
            r_rptr_src <= r_rptr;
            if (w_push) begin
                r_buf[w_widx] <= src_data_i;
                r_wptr        <= r_wptr + PtrOne;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rptr     <= '0;
            r_wptr_dst <= '0;
        end else if (dst_en_i) begin
            r_wptr_dst <= r_wptr;
            if (w_pop) r_rptr <= r_rptr + PtrOne;
        end
    end

    a_src_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (src_en_i && src_valid_i && !src_ready_o) |=> (src_valid_i && $stable(src_data_i)));

    a_dst_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (dst_valid_o && !(dst_en_i && dst_ready_i)) |=> dst_valid_o);

    a_occupancy: assert property (@(posedge clk_i) disable iff (rst_i)
        ((r_wptr - r_rptr) <= DepthP));

endmodule

// File: rtl/multirate_stream_bridge.sv
// Multi-channel enable-rate bridge: independent buffered channels, each
// with its own pointers; the top only slices the packed buses.
module multirate_stream_bridge
    import multirate_stream_bridge_pkg::*;
#(
    parameter int NumChannels = 1,
    parameter int DataWidth   = 32,
    parameter int Depth       = 2,
    parameter int PtrWidth    = ptr_width(Depth)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             src_en_i,
    input  logic                             dst_en_i,
    input  logic [NumChannels-1:0]           src_valid_i,
    output logic [NumChannels-1:0]           src_ready_o,
    input  logic [NumChannels*DataWidth-1:0] src_data_i,
    output logic [NumChannels-1:0]           dst_valid_o,
    input  logic [NumChannels-1:0]           dst_ready_i,
    output logic [NumChannels*DataWidth-1:0] dst_data_o
);

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        multirate_stream_bridge_channel #(
            .DataWidth (DataWidth),
            .Depth     (Depth),
            .PtrWidth  (PtrWidth)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .src_en_i    (src_en_i),
            .dst_en_i    (dst_en_i),
            .src_valid_i (src_valid_i[c]),
            .src_ready_o (src_ready_o[c]),
            .src_data_i  (src_data_i[c*DataWidth +: DataWidth]),
            .dst_valid_o (dst_valid_o[c]),
            .dst_ready_i (dst_ready_i[c]),
            .dst_data_o  (dst_data_o[c*DataWidth +: DataWidth])
        );
    end

endmodule

// File: tb/tb_multirate_stream_bridge.sv
// Directed bench for the multi-rate bridge: a 4-channel Depth=2 instance and
// a 1-channel Depth=1 instance sharing one clock.
module tb_multirate_stream_bridge;

    localparam int NCH = 4;
    localparam int DW  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               a_src_en, a_dst_en;
    logic [NCH-1:0]     a_src_valid, a_src_ready, a_dst_valid, a_dst_ready;
    logic [NCH*DW-1:0]  a_src_data, a_dst_data;
    logic               b_src_en, b_dst_en;
    logic [0:0]         b_src_valid, b_src_ready, b_dst_valid, b_dst_ready;
    logic [DW-1:0]      b_src_data, b_dst_data;

    int n_tests = 0;
    int n_fail  = 0;

    multirate_stream_bridge #(.NumChannels(NCH), .DataWidth(DW), .Depth(2)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .src_en_i(a_src_en), .dst_en_i(a_dst_en),
        .src_valid_i(a_src_valid), .src_ready_o(a_src_ready), .src_data_i(a_src_data),
        .dst_valid_o(a_dst_valid), .dst_ready_i(a_dst_ready), .dst_data_o(a_dst_data)
    );

    multirate_stream_bridge #(.NumChannels(1), .DataWidth(DW), .Depth(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .src_en_i(b_src_en), .dst_en_i(b_dst_en),
        .src_valid_i(b_src_valid), .src_ready_o(b_src_ready), .src_data_i(b_src_data),
        .dst_valid_o(b_dst_valid), .dst_ready_i(b_dst_ready), .dst_data_o(b_dst_data)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-channel stream of 8 items on channel 0 under divided enables.
    task automatic stream8(input string tag, input int sdiv, input int ddiv, input bit no_stall);
        int   sent = 0, recv = 0, viol = 0, stall = 0, cyc = 0;
        logic pv = 1'b0, pr = 1'b0, pse = 1'b0, pde = 1'b0;
        a_dst_ready[0] = 1'b1;
        while (recv < 8 && cyc < 400) begin
            a_src_en       = ((cyc % sdiv) == 0);
            a_dst_en       = ((cyc % ddiv) == 0);
            a_src_valid[0] = (sent < 8);
            a_src_data[7:0] = 8'(8'h40 + sent);
            if (cyc > 0) begin
                if (a_dst_valid[0] !== pv && !pde) viol++;
                if (a_src_ready[0] !== pr && !pse) viol++;
            end
            if (a_src_en && a_src_valid[0]) begin
                if (a_src_ready[0]) sent++;
                else stall++;
            end
            if (a_dst_en && a_dst_valid[0] && a_dst_ready[0]) begin
                chk($sformatf("%s_item%0d", tag, recv), 32'(a_dst_data[7:0]), 32'(8'h40 + recv));
                recv++;
            end
            pv = a_dst_valid[0]; pr = a_src_ready[0]; pse = a_src_en; pde = a_dst_en;
            tick();
            cyc++;
        end
        chk({tag, "_count"}, 32'(recv), 32'd8);
        chk({tag, "_enable_gating"}, 32'(viol), 32'd0);
        if (no_stall) chk({tag, "_stalls"}, 32'(stall), 32'd0);
        a_src_valid[0] = 1'b0;
        a_src_en = 1'b1;
        a_dst_en = 1'b1;
        repeat (6) tick();
        chk({tag, "_no_dup"}, 32'(a_dst_valid[0]), 32'd0);
        chk({tag, "_ready_back"}, 32'(a_src_ready[0]), 32'd1);
    endtask

    initial begin
        int   sent [NCH];
        int   recv [NCH];
        logic acc  [NCH];
        int   cyc;

        rst = 1'b1;
        a_src_en = 1'b0; a_dst_en = 1'b0; a_src_valid = '0; a_src_data = '0; a_dst_ready = '0;
        b_src_en = 1'b1; b_dst_en = 1'b1; b_src_valid = '0; b_src_data = '0; b_dst_ready = '1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_a_ready", 32'(a_src_ready), 32'hF);
        chk("rst_a_valid", 32'(a_dst_valid), 32'h0);
        chk("rst_a_data",  a_dst_data, 32'h0);
        chk("rst_b_ready", 32'(b_src_ready), 32'h1);
        chk("rst_b_valid", 32'(b_dst_valid), 32'h0);

        // Both enables high, back-to-back pushes into Depth=2 with dst stalled.
        a_src_en = 1'b1; a_dst_en = 1'b1;
        a_src_valid[0] = 1'b1; a_src_data[7:0] = 8'hA5;
        chk("t2_ready_first", 32'(a_src_ready[0]), 32'd1);
        tick();
        a_src_data[7:0] = 8'h5A;
        chk("t2_ready_second", 32'(a_src_ready[0]), 32'd1);
        chk("t2_valid_t1", 32'(a_dst_valid[0]), 32'd0);
        tick();
        a_src_valid[0] = 1'b0;
        chk("t2_full", 32'(a_src_ready[0]), 32'd0);
        chk("t2_valid_t2", 32'(a_dst_valid[0]), 32'd1);
        chk("t2_data_t2", 32'(a_dst_data[7:0]), 32'hA5);
        tick();
        chk("t2_hold_data", 32'(a_dst_data[7:0]), 32'hA5);
        a_dst_ready[0] = 1'b1;
        tick();
        chk("t2_pop2_valid", 32'(a_dst_valid[0]), 32'd1);
        chk("t2_pop2_data", 32'(a_dst_data[7:0]), 32'h5A);
        tick();
        chk("t2_empty_valid", 32'(a_dst_valid[0]), 32'd0);
        chk("t2_empty_data", 32'(a_dst_data[7:0]), 32'h0);
        tick(); tick();
        chk("t2_ready_again", 32'(a_src_ready[0]), 32'd1);

        // Reset while channel 0 holds two items.
        a_dst_ready[0] = 1'b0;
        a_src_valid[0] = 1'b1; a_src_data[7:0] = 8'h11;
        tick();
        a_src_data[7:0] = 8'h22;
        tick();
        a_src_valid[0] = 1'b0;
        chk("t1_holding", 32'(a_src_ready[0]), 32'd0);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("t1_ready", 32'(a_src_ready), 32'hF);
        chk("t1_valid", 32'(a_dst_valid), 32'h0);
        chk("t1_data",  a_dst_data, 32'h0);
        a_dst_ready[0] = 1'b1;
        repeat (3) tick();
        chk("t1_discarded", 32'(a_dst_valid[0]), 32'd0);

        stream8("t3_ratio_1_3", 1, 3, 1'b0);
        stream8("t4_ratio_4_1", 4, 1, 1'b1);

        // Depth=1: the second push waits for the pop to travel back.
        b_src_valid = 1'b1; b_src_data = 8'h3C;
        chk("t5_c0_ready", 32'(b_src_ready), 32'd1);
        tick();
        b_src_data = 8'hC3;
        chk("t5_c1_ready", 32'(b_src_ready), 32'd0);
        chk("t5_c1_valid", 32'(b_dst_valid), 32'd0);
        tick();
        chk("t5_c2_ready", 32'(b_src_ready), 32'd0);
        chk("t5_c2_valid", 32'(b_dst_valid), 32'd1);
        chk("t5_c2_data",  32'(b_dst_data), 32'h3C);
        tick();
        chk("t5_c3_ready", 32'(b_src_ready), 32'd0);
        chk("t5_c3_valid", 32'(b_dst_valid), 32'd0);
        tick();
        chk("t5_c4_ready", 32'(b_src_ready), 32'd1);
        tick();
        b_src_valid = 1'b0;
        chk("t5_c5_ready", 32'(b_src_ready), 32'd0);
        chk("t5_c5_valid", 32'(b_dst_valid), 32'd0);
        tick();
        chk("t5_c6_valid", 32'(b_dst_valid), 32'd1);
        chk("t5_c6_data",  32'(b_dst_data), 32'hC3);
        tick();
        chk("t5_c7_valid", 32'(b_dst_valid), 32'd0);

        // Four channels, random enables/valid/ready, channel 2 never drained.
        for (int c = 0; c < NCH; c++) begin
            sent[c] = 0; recv[c] = 0; acc[c] = 1'b0;
        end
        a_src_valid = '0;
        cyc = 0;
        while (cyc < 3000 && !(recv[0] == 20 && recv[1] == 20 && recv[3] == 20)) begin
            a_src_en = 1'($urandom_range(0, 1));
            a_dst_en = 1'($urandom_range(0, 1));
            for (int c = 0; c < NCH; c++) begin
                if (!a_src_valid[c] && sent[c] < 20 && $urandom_range(0, 2) != 0) begin
                    a_src_valid[c] = 1'b1;
                    a_src_data[c*DW +: DW] = 8'((c << 6) | sent[c]);
                end
                a_dst_ready[c] = (c == 2) ? 1'b0 : 1'($urandom_range(0, 1));
                acc[c] = a_src_en && a_src_valid[c] && a_src_ready[c];
                if (acc[c]) sent[c]++;
                if (a_dst_en && a_dst_valid[c] && a_dst_ready[c]) begin
                    chk($sformatf("t6_ch%0d_item%0d", c, recv[c]),
                        32'(a_dst_data[c*DW +: DW]), 32'((c << 6) | recv[c]));
                    recv[c]++;
                end
            end
            tick();
            for (int c = 0; c < NCH; c++) if (acc[c]) a_src_valid[c] = 1'b0;
            cyc++;
        end
        chk("t6_ch0_count", 32'(recv[0]), 32'd20);
        chk("t6_ch1_count", 32'(recv[1]), 32'd20);
        chk("t6_ch3_count", 32'(recv[3]), 32'd20);
        chk("t6_ch2_recv",  32'(recv[2]), 32'd0);
        chk("t6_ch2_sent",  32'(sent[2]), 32'd2);
        chk("t6_ch2_valid", 32'(a_dst_valid[2]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multirate_stream_bridge.md
Name: multirate_stream_bridge

Overview:
Multi-channel, buffered handshake bridge between two rate domains that share one physical clock. Each side advances only on its own clock-enable strobe, so integer-ratio "isochronous" domains are modelled by enables instead of separate clocks. Each channel carries data through a small per-channel buffer. Each side sees the other's pointer only through an enable-gated register stage, giving the same one-side-at-a-time visibility as a toggle-based 4-phase crossing. The block is the successor to the single-bit, unbuffered isochronous handshake and is used at subsystem boundaries driven by divided clock enables.

Parameters:
NumChannels, 1, number of independent valid/ready/data channels (>=1)
DataWidth, 32, payload bits per channel (>=1)
Depth, 2, buffer entries per channel; power of two, >=1; Depth=1 gives classic 4-phase behaviour
PtrWidth, $clog2(Depth)+1, derived; do not override

Ports:
clk_i  in  1  single clock for both domains
rst_i  in  1  reset; synchronous, active-high
src_en_i  in  1  source-domain enable; source-side state updates only when 1
dst_en_i  in  1  destination-domain enable; destination-side state updates only when 1
src_valid_i  in  NumChannels  per-channel source valid
src_ready_o  out  NumChannels  per-channel source ready
src_data_i  in  NumChannels*DataWidth  payload; channel c occupies bits [c*DataWidth +: DataWidth]
dst_valid_o  out  NumChannels  per-channel destination valid
dst_ready_i  in  NumChannels  per-channel destination ready
dst_data_o  out  NumChannels*DataWidth  payload, same packing as src_data_i

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - all pointers, synchronised copies and buffer contents clear to 0.
  - src_ready_o = all ones, dst_valid_o = 0, dst_data_o = 0.
  - Reset takes precedence over all enables and handshakes in the same cycle.
- Per channel c, registers:
  - wptr (PtrWidth, source side)
  - rptr (PtrWidth, destination side)
  - wptr_dst: loads wptr only on cycles with dst_en_i=1
  - rptr_src: loads rptr only on cycles with src_en_i=1
  - Pointer arithmetic is modulo 2^PtrWidth. The MSB is the wrap bit.
- Source handshake: src_en_i & src_valid_i[c] & src_ready_o[c].
  - Writes src_data_i slice into buf[wptr[PtrWidth-2:0]].
  - Increments wptr. For Depth=1, index is 0.
- src_ready_o[c] = ((wptr - rptr_src) != Depth).
  - Combinational from registers only; no path from src_valid_i.
- Destination handshake: dst_en_i & dst_valid_o[c] & dst_ready_i[c].
  - Increments rptr.
- dst_valid_o[c] = (wptr_dst != rptr).
  - dst_data_o slice = buf[rptr index] when valid, otherwise 0.
- Consequence: dst outputs change only after dst_en_i cycles; src_ready_o changes only after src_en_i cycles.
- Latency, accept to visible:
  - Source handshake in cycle t sets wptr at the edge ending t.
  - dst_valid_o rises the cycle after the first dst_en_i=1 cycle >= t+1.
  - With both enables tied high: accept at t -> dst_valid_o at t+2.
- Release latency: consumption at dst cycle u frees the slot at the source the cycle after the first src_en_i=1 cycle >= u+1.
  - With enables tied high: round-trip throughput is Depth items per 4 cycles, capped at 1 per cycle.
- Full: no write when full; src_valid_i held while full is legal and is not lost.
- Empty: dst_valid_o = 0 and dst_ready_i is ignored.
- Simultaneous source and destination handshakes on the same channel in the same cycle are legal.
  - Buffer write and read indices can never coincide, because the read slot is still counted as occupied in rptr_src.
- Channels are fully independent; there is no arbitration and no cross-channel ordering.
- Enables low: the corresponding side's pointers and copies hold; data in flight is never dropped.
- Protocol rules, enforced by assertions (simulation only):
  - src_valid_i and src_data_i stay stable while valid & !ready across src-enabled cycles.
  - dst_valid_o never drops without a destination handshake.
  - The occupancy wptr - rptr never exceeds Depth.

Decomposition:
- Package multirate_stream_bridge_pkg: no types required beyond the PtrWidth derivation; keep the derivation local unless reused.
- Sub-module multirate_stream_bridge_channel: one channel's pointers, synchronised copies and buffer.
- Top level generates NumChannels instances and does the bus slicing.

Test Plan:
1. Reset: rst_i=1 for 2 cycles mid-transfer (channel 0 holding 2 items) -> next cycle src_ready_o=all ones, dst_valid_o=0; items discarded.
2. Both enables high, Depth=2, NumChannels=1: push 0xA5, 0x5A back-to-back with dst_ready_i=0 -> src_ready_o=0 after the 2nd accept; dst_valid_o=1 with data 0xA5 at t+2; releasing dst_ready_i pops 0xA5 then 0x5A.
3. Ratio 1:3 (src_en_i every cycle, dst_en_i every 3rd cycle), 8 items 0..7 with dst_ready_i=1 -> all 8 items received in order; dst_valid_o transitions only the cycle after dst_en_i pulses.
4. Ratio 4:1 (src_en_i every 4th cycle): src_valid_i held high continuously -> exactly one accept per src_en_i pulse; no duplicate data at dst.
5. Depth=1: alternate push/pop -> behaves as a 4-phase handshake; second push blocked until the dst pop propagates back via src_en_i.
6. NumChannels=4, random valid/ready per channel, random enables -> per-channel in-order, lossless, duplicate-free scoreboard match; channel 2 stalled indefinitely does not block channels 0, 1, 3.
